issue_queue_n: RTL

Parametrised out-of-order issue queue between dispatch and one execution unit. Holds up to DEPTH renamed instructions and captures missing source operands from the common data bus (CDB). Each cycle it offers the oldest entry whose operands are both valid. Supersedes the fixed 4-entry queue with:
- configurable depth and widths;
- a valid/ready issue handshake;
- same-cycle CDB capture on dispatch;
- a synchronous flush.

---
 rtl/iq_pkg.sv | 41 ++++
 rtl/iq_slot.sv | 48 ++++
 rtl/issue_queue_n.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/iq_pkg.sv
// Shared types and helpers for the out-of-order issue queue.
// Entry fields are sized to the widest supported widths; narrower instances zero-extend.
package iq_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int TAG_W_DEF  = 6;
   localparam int DATA_W_MAX = 64;
   localparam int TAG_W_MAX  = 8;

   typedef struct packed {
      logic                  occ;
      logic                  rs1_valid;
      logic [TAG_W_MAX-1:0]  rs1_tag;
      logic [DATA_W_MAX-1:0] rs1_data;
      logic                  rs2_valid;
      logic [TAG_W_MAX-1:0]  rs2_tag;
      logic [DATA_W_MAX-1:0] rs2_data;
      logic [TAG_W_MAX:0]    rd_token;
      logic [6:0]            opcode;
      logic [2:0]            funct3;
      logic [6:0]            funct7;
      logic [DATA_W_MAX-1:0] imm;
      logic [DATA_W_MAX-1:0] pc;
   } iq_entry_t;

   typedef enum logic [1:0] {
      SEL_HOLD  = 2'd0,
      SEL_SHIFT = 2'd1,
      SEL_LOAD  = 2'd2,
      SEL_CLEAR = 2'd3
   } slot_sel_e;

   // True when a still-missing operand is satisfied by this cycle's broadcast.
   function automatic logic tag_match(input logic                 valid,
                                      input logic [TAG_W_MAX-1:0] tag,
                                      input logic                 cdb_valid,
                                      input logic [TAG_W_MAX-1:0] cdb_tag);
      return !valid && cdb_valid && (tag == cdb_tag);
   endfunction

endpackage

// File: rtl/iq_slot.sv
// One issue-queue entry register with next-value select and CDB operand capture.
// Registered output; the capture applies to whichever value is being written this cycle.
module iq_slot
   import iq_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  slot_sel_e             sel,
   input  iq_entry_t             above_entry,
   input  iq_entry_t             load_entry,
   input  logic                  cdb_valid,
   input  logic [TAG_W_MAX-1:0]  cdb_tag,
   input  logic [DATA_W_MAX-1:0] cdb_data,
   output iq_entry_t             entry,
   output logic                  ready
);

   iq_entry_t entry_q, entry_d, base;

   always_comb begin
      base = entry_q;
      case (sel)
         SEL_SHIFT: base = above_entry;
         SEL_LOAD:  base = load_entry;
         SEL_CLEAR: base = '0;
         default:   base = entry_q;
      endcase

      entry_d = base;
      if (base.occ && tag_match(base.rs1_valid, base.rs1_tag, cdb_valid, cdb_tag)) begin
         entry_d.rs1_valid = 1'b1;
         entry_d.rs1_data  = cdb_data;
      end
      if (base.occ && tag_match(base.rs2_valid, base.rs2_tag, cdb_valid, cdb_tag)) begin
         entry_d.rs2_valid = 1'b1;
         entry_d.rs2_data  = cdb_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) entry_q <= '0;
      else     entry_q <= entry_d;
   end

   assign entry = entry_q;
   assign ready = entry_q.occ & entry_q.rs1_valid & entry_q.rs2_valid;

endmodule

// File: rtl/issue_queue_n.sv
// Collapsing out-of-order issue queue: oldest ready entry offered on a valid/ready port.
// Dispatch-to-issue 1 cycle; disp_ready = count < DEPTH (no same-cycle slot reuse when full).
module issue_queue_n
   import iq_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = DATA_W_DEF,
   parameter int TAG_W  = TAG_W_DEF,
   parameter int IMM_EN = 1,
   parameter int PC_EN  = 1
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         disp_valid,
   output logic                         disp_ready,
   input  logic [DATA_W-1:0]            disp_rs1_data,
   input  logic [DATA_W-1:0]            disp_rs2_data,
   input  logic [TAG_W-1:0]             disp_rs1_tag,
   input  logic [TAG_W-1:0]             disp_rs2_tag,
   input  logic                         disp_rs1_valid,
   input  logic                         disp_rs2_valid,
   input  logic [TAG_W:0]               disp_rd_token,
   input  logic [6:0]                   disp_opcode,
   input  logic [6:0]                   disp_funct7,
   input  logic [2:0]                   disp_funct3,
   input  logic [DATA_W-1:0]            disp_imm,
   input  logic [DATA_W-1:0]            disp_pc,
   input  logic                         cdb_valid,
   input  logic [TAG_W-1:0]             cdb_tag,
   input  logic [DATA_W-1:0]            cdb_data,
   input  logic                         flush,
   output logic                         issue_valid,
   input  logic                         issue_ready,
   output logic [DATA_W-1:0]            issue_rs1_data,
   output logic [DATA_W-1:0]            issue_rs2_data,
   output logic [DATA_W-1:0]            issue_imm,
   output logic [DATA_W-1:0]            issue_pc,
   output logic [TAG_W:0]               issue_rd_token,
   output logic [6:0]                   issue_opcode,
   output logic [6:0]                   issue_funct7,
   output logic [2:0]                   issue_funct3,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int IW = $clog2(DEPTH);

   iq_entry_t  entries   [DEPTH];
   iq_entry_t  above     [DEPTH];
   slot_sel_e  slot_sel  [DEPTH];
   logic [DEPTH-1:0] ready_vec;

   iq_entry_t  load_entry, sel_entry;
   logic [IW-1:0] sel_idx;
   logic [CW-1:0] count_q, count_d, ins_idx;
   logic any_ready, issue_fire, disp_fire;
   logic unused_sel;

   always_comb begin
      load_entry           = '0;
      load_entry.occ       = 1'b1;
      load_entry.rs1_valid = disp_rs1_valid;
      load_entry.rs1_tag   = TAG_W_MAX'(disp_rs1_tag);
      load_entry.rs1_data  = DATA_W_MAX'(disp_rs1_data);
      load_entry.rs2_valid = disp_rs2_valid;
      load_entry.rs2_tag   = TAG_W_MAX'(disp_rs2_tag);
      load_entry.rs2_data  = DATA_W_MAX'(disp_rs2_data);
      load_entry.rd_token  = (TAG_W_MAX+1)'(disp_rd_token);
      load_entry.opcode    = disp_opcode;
      load_entry.funct3    = disp_funct3;
      load_entry.funct7    = disp_funct7;
      load_entry.imm       = (IMM_EN != 0) ? DATA_W_MAX'(disp_imm) : '0;
      load_entry.pc        = (PC_EN != 0)  ? DATA_W_MAX'(disp_pc)  : '0;
   end

   // Lowest index wins: slot 0 is the oldest entry.
   always_comb begin
      any_ready = 1'b0;
      sel_idx   = '0;
      for (int i = DEPTH-1; i >= 0; i--) begin
         if (ready_vec[i]) begin
            any_ready = 1'b1;
            sel_idx   = IW'(i);
         end
      end
   end

   assign disp_ready  = (count_q < CW'(DEPTH));
   assign issue_valid = any_ready && !flush;
   assign issue_fire  = issue_valid && issue_ready;
   assign disp_fire   = disp_valid && disp_ready && !flush;
   assign ins_idx     = issue_fire ? (count_q - CW'(1)) : count_q;

   // A slot loaded with the new entry never also needs the shifted copy: the
   // slot above the insert point is always empty.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         slot_sel[i] = SEL_HOLD;
         if (flush)
            slot_sel[i] = SEL_CLEAR;
         else if (disp_fire && (ins_idx == CW'(i)))
            slot_sel[i] = SEL_LOAD;
         else if (issue_fire && (IW'(i) >= sel_idx))
            slot_sel[i] = SEL_SHIFT;
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH-1; i++) above[i] = entries[i+1];
      above[DEPTH-1] = '0;
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_slot
      iq_slot u_slot (
         .clk         (clk),
         .rst         (rst),
         .sel         (slot_sel[g]),
         .above_entry (above[g]),
         .load_entry  (load_entry),
         .cdb_valid   (cdb_valid),
         .cdb_tag     (TAG_W_MAX'(cdb_tag)),
         .cdb_data    (DATA_W_MAX'(cdb_data)),
         .entry       (entries[g]),
         .ready       (ready_vec[g])
      );
   end

   always_comb begin
      count_d = count_q;
      if (flush)
         count_d = '0;
      else begin
         case ({disp_fire, issue_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count = count_q;

   assign sel_entry      = issue_valid ? entries[sel_idx] : '0;
   assign issue_rs1_data = sel_entry.rs1_data[DATA_W-1:0];
   assign issue_rs2_data = sel_entry.rs2_data[DATA_W-1:0];
   assign issue_imm      = (IMM_EN != 0) ? sel_entry.imm[DATA_W-1:0] : '0;
   assign issue_pc       = (PC_EN != 0)  ? sel_entry.pc[DATA_W-1:0]  : '0;
   assign issue_rd_token = sel_entry.rd_token[TAG_W:0];
   assign issue_opcode   = sel_entry.opcode;
   assign issue_funct7   = sel_entry.funct7;
   assign issue_funct3   = sel_entry.funct3;

   // Zero-extension headroom and the occupied bit are never driven out.
   assign unused_sel = ^sel_entry;

endmodule
